kamikaze_memory: RTL and testbench
==================================

# kamikaze_memory

Memory-access stage of the kamikaze RV32I pipeline, directly downstream of the execute stage. Consumes the registered ALU result, destination register and write-enable, performs loads and stores on the data bus with a req/ack handshake, and presents aligned write-back data to the write-back stage. Stalls upstream stages while a bus transaction is outstanding.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  execute output carries a valid instruction
- result_i  in  32  ALU result; memory address for loads and stores, write-back value otherwise
- store_data_i  in  32  rs2 value for stores
- mem_op_i  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- mem_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rf_rd_i  in  5  destination register
- rf_rd_we_i  in  1  destination write enable
- stall_o  out  1  hold execute and earlier stages
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  32  word address, bits [1:0] = 0
- dbus_be_o  out  4  byte enables
- dbus_wdata_o  out  32  replicated store data
- dbus_rdata_i  in  32  read data, valid with ack
- dbus_ack_i  in  1  transaction complete
- wb_valid_o  out  1  write-back entry valid
- wb_data_o  out  32  write-back value
- wb_rd_o  out  5  write-back register
- wb_we_o  out  1  write-back enable (0 when rd = x0)
- misalign_o, badaddr_o [32]  out  only with KAMIKAZE_MISALIGN_TRAP_EN

## Operation
- FSM: IDLE, BUS.
- IDLE, valid_i, mem_op none: next cycle wb_valid_o=1, wb_data_o=result_i, wb_we_o=rf_rd_we_i & (rf_rd_i!=0).
- IDLE, valid_i, load/store: stall_o=1 combinationally; latch address, size, op, rd, we, store data; go BUS.
- BUS: dbus_req_o=1; addr/we/be/wdata stable until ack; stall_o=1. On dbus_ack_i: go IDLE, wb_valid_o=1 next cycle.
- Store: SB be=0001<<addr[1:0], wdata={4{byte}}; SH be=addr[1]?1100:0011, wdata={2{half}}; SW be=1111. wb_we_o=0.
- Load: rdata >> 8*addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged.
- Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0 (handling under Configuration).
- dbus_ack_i outside BUS ignored. valid_i=0 in IDLE: wb_valid_o=0, wb_we_o=0.

## Timing
- Reset: state IDLE; every output 0 (dbus_req_o drops asynchronously, abandoning any transaction).
- Non-memory latency 1 cycle. Memory: req rises cycle after accept; wb_valid_o 1 cycle after ack; minimum 3 cycles accept to write-back (ack in first BUS cycle).
- stall_o falls in the ack cycle; the next instruction is accepted on the edge ending it.
- dbus_req_o falls the cycle after ack; no back-to-back req without an IDLE cycle.
- wb_* registered; wb_valid_o is a one-cycle pulse per instruction.

## Configuration
- KAMIKAZE_MISALIGN_TRAP_EN defined: misaligned access issues no bus request, stays IDLE, pulses misalign_o 1 cycle with badaddr_o=address, wb_valid_o=1 and wb_we_o=0. badaddr_o holds until the next misalign.
- Undefined: address low bits forced to natural alignment (H clears bit 0, W clears bits [1:0]); access proceeds; ports absent.

## Structure
- riscv_defines.v gains MEM_OP_NONE/LOAD/STORE and MEM_SIZE_B/H/W/BU/HU constants, shared with decode.
- Sub-module kamikaze_load_align: combinational rdata, addr[1:0], size -> extended result.

## Test plan
- ALU passthrough: result_i=0x1234, rd=5, we=1 -> next cycle wb_data_o=0x1234, wb_rd_o=5, wb_we_o=1, no req.
- SB addr 0x103, data 0xAB -> dbus_addr_o=0x100, be=1000, wdata=0xABABABAB; ack after 3 wait cycles -> stall_o high 4 cycles, wb_we_o=0.
- LB addr 0x102, rdata 0x00800000 -> wb_data_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102, rdata 0xBEEF0000 -> 0x0000BEEF.
- LW to rd=0, rdata 0xDEADBEEF -> wb_valid_o=1, wb_we_o=0.
- LW addr 0x101: macro on -> misalign_o=1, badaddr_o=0x101, no req; macro off -> dbus_addr_o=0x100, be=1111.
- rst_i low during BUS -> dbus_req_o=0 immediately; after release, IDLE with all outputs 0; late ack ignored.

Source files
------------

// File: rtl/kamikaze_memory_pkg.sv
// Shared memory-stage constants and helpers for the kamikaze RV32I pipeline.
// The decode stage emits the same MEM_OP_* / MEM_SIZE_* encodings.
package kamikaze_memory_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  // funct3 encodings; bit 2 selects zero-extension for loads
  localparam logic [2:0] MEM_SIZE_B  = 3'b000;
  localparam logic [2:0] MEM_SIZE_H  = 3'b001;
  localparam logic [2:0] MEM_SIZE_W  = 3'b010;
  localparam logic [2:0] MEM_SIZE_BU = 3'b100;
  localparam logic [2:0] MEM_SIZE_HU = 3'b101;

  typedef enum logic {ST_IDLE, ST_BUS} state_e;

  // Halfword accesses need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] sz, input logic [1:0] lo);
    case (sz[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  // Force the address to the natural alignment of the access size.
  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [2:0] sz);
    case (sz[1:0])
      2'b00:   return a;
      2'b01:   return {a[31:1], 1'b0};
      default: return {a[31:2], 2'b00};
    endcase
  endfunction

  function automatic logic [3:0] gen_be(input logic [2:0] sz, input logic [1:0] lo);
    case (sz[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across the word so the byte lanes pick it up.
  function automatic logic [31:0] gen_wdata(input logic [2:0] sz, input logic [31:0] d);
    case (sz[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/kamikaze_load_align.sv
// Load data aligner: shifts the addressed byte/half down to bit 0 and extends it.
module kamikaze_load_align
  import kamikaze_memory_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_size,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;
  logic        w_sext;

  assign w_sh   = i_rdata >> {i_addr, 3'b000};
  assign w_sext = ~i_size[2];

  // select width and extension
  always_comb begin
    o_data = i_rdata;
    case (i_size[1:0])
      2'b00:   o_data = {{24{w_sext & w_sh[7]}}, w_sh[7:0]};
      2'b01:   o_data = {{16{w_sext & w_sh[15]}}, w_sh[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/kamikaze_memory.sv
// kamikaze memory-access stage: loads/stores over a req/ack data bus,
// registered write-back outputs, upstream stall while the bus is busy.
// Optional KAMIKAZE_MISALIGN_TRAP_EN: misaligned accesses trap instead of
// being silently aligned.
module kamikaze_memory
  import kamikaze_memory_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] result_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  mem_op_i,
  input  logic [2:0]  mem_size_i,
  input  logic [4:0]  rf_rd_i,
  input  logic        rf_rd_we_i,
  output logic        stall_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_we_o
`ifdef KAMIKAZE_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o,
  output logic [31:0] badaddr_o
`endif
);

  state_e      r_state, w_state_nxt;
  logic        w_is_mem, w_trap, w_accept, w_stall, w_done;
  logic [31:0] w_addr, w_ld_data;

  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [2:0]  r_size;
  logic        r_store, r_rd_we;
  logic [4:0]  r_rd;

  logic        r_wb_valid, r_wb_we;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;

  assign w_is_mem = valid_i & ((mem_op_i == MEM_OP_LOAD) | (mem_op_i == MEM_OP_STORE));

`ifdef KAMIKAZE_MISALIGN_TRAP_EN
  logic        r_misalign;
  logic [31:0] r_badaddr;

  assign w_trap = w_is_mem & (r_state == ST_IDLE) & is_misaligned(mem_size_i, result_i[1:0]);
  assign w_addr = result_i;

  // one-cycle misalign pulse; faulting address held until the next trap
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_misalign <= 1'b0;
      r_badaddr  <= '0;
    end else begin
      r_misalign <= w_trap;
      if (w_trap) r_badaddr <= result_i;
    end
  end

  assign misalign_o = r_misalign;
  assign badaddr_o  = r_badaddr;
`else
  assign w_trap = 1'b0;
  assign w_addr = align_addr(result_i, mem_size_i);
`endif

  assign w_accept = (r_state == ST_IDLE) & w_is_mem & ~w_trap;

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next state, stall and completion strobe
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt = ST_BUS;
        w_stall     = 1'b1;
      end
      ST_BUS: begin
        w_stall = ~dbus_ack_i;
        if (dbus_ack_i) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // gated so every output reads 0 while reset is held
  assign stall_o = w_stall & rst_i;

  // capture the access at accept; held stable for the whole bus phase
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_size  <= '0;
      r_store <= 1'b0;
      r_rd    <= '0;
      r_rd_we <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= w_addr;
      r_wdata <= gen_wdata(mem_size_i, store_data_i);
      r_be    <= gen_be(mem_size_i, w_addr[1:0]);
      r_size  <= mem_size_i;
      r_store <= (mem_op_i == MEM_OP_STORE);
      r_rd    <= rf_rd_i;
      r_rd_we <= rf_rd_we_i;
    end
  end

  assign dbus_req_o   = (r_state == ST_BUS);
  assign dbus_we_o    = r_store;
  assign dbus_addr_o  = {r_addr[31:2], 2'b00};
  assign dbus_be_o    = r_be;
  assign dbus_wdata_o = r_wdata;

  kamikaze_load_align u_align (
    .i_rdata (dbus_rdata_i),
    .i_addr  (r_addr[1:0]),
    .i_size  (r_size),
    .o_data  (w_ld_data)
  );

  // write-back register: pulse on bus completion or on a non-bus instruction
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      if (w_done) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= w_ld_data;
        r_wb_rd    <= r_rd;
        r_wb_we    <= ~r_store & r_rd_we & (r_rd != 5'd0);
      end else if ((r_state == ST_IDLE) && valid_i && !w_accept) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= result_i;
        r_wb_rd    <= rf_rd_i;
        r_wb_we    <= ~w_trap & rf_rd_we_i & (rf_rd_i != 5'd0);
      end
    end
  end

  assign wb_valid_o = r_wb_valid;
  assign wb_data_o  = r_wb_data;
  assign wb_rd_o    = r_wb_rd;
  assign wb_we_o    = r_wb_we;

endmodule

// File: tb/tb_kamikaze_memory.sv
// Directed bench for kamikaze_memory; honours KAMIKAZE_MISALIGN_TRAP_EN.
module tb_kamikaze_memory;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] result_i = '0;
  logic [31:0] store_data_i = '0;
  logic [1:0]  mem_op_i = '0;
  logic [2:0]  mem_size_i = '0;
  logic [4:0]  rf_rd_i = '0;
  logic        rf_rd_we_i = 1'b0;
  logic        stall_o, dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_rdata_i = '0;
  logic        dbus_ack_i = 1'b0;
  logic        wb_valid_o, wb_we_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
`ifdef KAMIKAZE_MISALIGN_TRAP_EN
  logic        misalign_o;
  logic [31:0] badaddr_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  int          stalls;

  always #5 clk_i = ~clk_i;

  kamikaze_memory dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .result_i     (result_i),
    .store_data_i (store_data_i),
    .mem_op_i     (mem_op_i),
    .mem_size_i   (mem_size_i),
    .rf_rd_i      (rf_rd_i),
    .rf_rd_we_i   (rf_rd_we_i),
    .stall_o      (stall_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_rdata_i (dbus_rdata_i),
    .dbus_ack_i   (dbus_ack_i),
    .wb_valid_o   (wb_valid_o),
    .wb_data_o    (wb_data_o),
    .wb_rd_o      (wb_rd_o),
    .wb_we_o      (wb_we_o)
`ifdef KAMIKAZE_MISALIGN_TRAP_EN
    ,
    .misalign_o   (misalign_o),
    .badaddr_o    (badaddr_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one memory instruction, hold it while stalled, ack after `waits`
  // BUS cycles. Returns with time just after the edge that loads wb_*.
  task automatic mem_op(input logic [1:0] op, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input logic we,
                        input logic [31:0] rdata, input int waits);
    valid_i = 1'b1; mem_op_i = op; mem_size_i = sz; result_i = addr;
    store_data_i = sd; rf_rd_i = rd; rf_rd_we_i = we;
    stalls = 0;
    @(negedge clk_i);
    if (stall_o) stalls++;
    tick();
    for (int i = 0; i <= waits; i++) begin
      dbus_ack_i   = (i == waits);
      dbus_rdata_i = (i == waits) ? rdata : 32'h0;
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (i == 0) begin
        chk("req_in_bus", {31'd0, dbus_req_o}, 32'd1);
        cap_addr = dbus_addr_o; cap_be = dbus_be_o;
        cap_wdata = dbus_wdata_o; cap_we = dbus_we_o;
      end
      tick();
    end
    dbus_ack_i = 1'b0;
    valid_i = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_ctl", {25'd0, dbus_req_o, dbus_we_o, stall_o, wb_valid_o, wb_we_o, 2'b00}, 32'd0);
    chk("rst_bus", dbus_addr_o | dbus_wdata_o | {28'd0, dbus_be_o}, 32'd0);
    chk("rst_wb", wb_data_o | {27'd0, wb_rd_o}, 32'd0);
    @(negedge clk_i); rst_i = 1'b1;
    tick();

    // ALU passthrough
    valid_i = 1'b1; mem_op_i = 2'b00; result_i = 32'h1234; rf_rd_i = 5'd5; rf_rd_we_i = 1'b1;
    @(negedge clk_i);
    chk("pt_stall", {31'd0, stall_o}, 32'd0);
    tick();
    valid_i = 1'b0;
    chk("pt_wb", {wb_valid_o, wb_we_o, 25'd0, wb_rd_o}, {2'b11, 25'd0, 5'd5});
    chk("pt_data", wb_data_o, 32'h1234);
    chk("pt_noreq", {31'd0, dbus_req_o}, 32'd0);
    tick();
    chk("pt_pulse", {30'd0, wb_valid_o, wb_we_o}, 32'd0);

    // SB 0x103 with three wait cycles
    mem_op(2'b10, 3'b000, 32'h103, 32'h000000AB, 5'd7, 1'b1, 32'h0, 3);
    chk("sb_addr", cap_addr, 32'h100);
    chk("sb_be", {28'd0, cap_be}, 32'h8);
    chk("sb_wdata", cap_wdata, 32'hABABABAB);
    chk("sb_we", {31'd0, cap_we}, 32'd1);
    chk("sb_stalls", stalls, 32'd4);
    chk("sb_wb", {30'd0, wb_valid_o, wb_we_o}, 32'h2);
    chk("sb_req_drop", {31'd0, dbus_req_o}, 32'd0);

    // SH 0x102, SW 0x200 (ack in first BUS cycle)
    mem_op(2'b10, 3'b001, 32'h102, 32'h1234ABCD, 5'd1, 1'b0, 32'h0, 0);
    chk("sh_be", {28'd0, cap_be}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCDABCD);
    mem_op(2'b10, 3'b010, 32'h200, 32'hCAFEF00D, 5'd1, 1'b0, 32'h0, 0);
    chk("sw_be", {28'd0, cap_be}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'hCAFEF00D);
    chk("sw_stalls", stalls, 32'd1);

    // loads
    mem_op(2'b01, 3'b000, 32'h102, 32'h0, 5'd9, 1'b1, 32'h00800000, 1);
    chk("lb_we", {cap_we, 3'd0, cap_be, wb_valid_o, wb_we_o, 22'd0}, {1'b0, 3'd0, 4'b0100, 2'b11, 22'd0});
    chk("lb_data", wb_data_o, 32'hFFFFFF80);
    chk("lb_rd", {27'd0, wb_rd_o}, 32'd9);
    mem_op(2'b01, 3'b100, 32'h102, 32'h0, 5'd9, 1'b1, 32'h00800000, 0);
    chk("lbu_data", wb_data_o, 32'h00000080);
    mem_op(2'b01, 3'b101, 32'h102, 32'h0, 5'd9, 1'b1, 32'hBEEF0000, 0);
    chk("lhu_data", wb_data_o, 32'h0000BEEF);
    mem_op(2'b01, 3'b001, 32'h102, 32'h0, 5'd9, 1'b1, 32'hBEEF0000, 2);
    chk("lh_data", wb_data_o, 32'hFFFFBEEF);
    mem_op(2'b01, 3'b010, 32'h300, 32'h0, 5'd0, 1'b1, 32'hDEADBEEF, 0);
    chk("lw_x0", {30'd0, wb_valid_o, wb_we_o}, 32'h2);
    chk("lw_x0_data", wb_data_o, 32'hDEADBEEF);

    // stray ack while idle
    dbus_ack_i = 1'b1;
    tick();
    dbus_ack_i = 1'b0;
    tick();
    chk("stray_ack", {30'd0, dbus_req_o, wb_valid_o}, 32'd0);

    // misaligned LW 0x101
`ifdef KAMIKAZE_MISALIGN_TRAP_EN
    valid_i = 1'b1; mem_op_i = 2'b01; mem_size_i = 3'b010; result_i = 32'h101;
    rf_rd_i = 5'd4; rf_rd_we_i = 1'b1;
    @(negedge clk_i);
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    tick();
    valid_i = 1'b0;
    chk("mis_flags", {28'd0, misalign_o, dbus_req_o, wb_valid_o, wb_we_o}, 32'b1010);
    chk("mis_badaddr", badaddr_o, 32'h101);
    tick();
    chk("mis_pulse", {30'd0, misalign_o, dbus_req_o}, 32'd0);
    chk("mis_hold", badaddr_o, 32'h101);
`else
    mem_op(2'b01, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1, 32'h11223344, 0);
    chk("mis_addr", cap_addr, 32'h100);
    chk("mis_be", {28'd0, cap_be}, 32'hF);
    chk("mis_data", wb_data_o, 32'h11223344);
`endif

    // reset during BUS, then a late ack
    valid_i = 1'b1; mem_op_i = 2'b01; mem_size_i = 3'b010; result_i = 32'h400;
    rf_rd_i = 5'd6; rf_rd_we_i = 1'b1;
    tick();
    chk("rb_req", {31'd0, dbus_req_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rb_req_async", {31'd0, dbus_req_o}, 32'd0);
    valid_i = 1'b0;
    tick();
    chk("rb_outs", {dbus_addr_o[29:0], stall_o, wb_valid_o}, 32'd0);
    @(negedge clk_i); rst_i = 1'b1;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h55555555;
    tick();
    dbus_ack_i = 1'b0;
    chk("late_ack", {28'd0, dbus_req_o, stall_o, wb_valid_o, wb_we_o}, 32'd0);
    tick();
    chk("late_ack2", {30'd0, dbus_req_o, wb_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
